// File: rtl/reg_bank_rw_pkg.sv
// Shared CPU definitions: register-file geometry and architectural register indices.
// The write-register selector and the register bank both take these indices from here.
package reg_bank_rw_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
    localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

    // Selector encodings for the write-register source (rt, 29, 31, rd).
    typedef enum logic [1:0] {
        WrSelRt = 2'd0,
        WrSelSp = 2'd1,
        WrSelRa = 2'd2,
        WrSelRd = 2'd3
    } wr_sel_e;

endpackage

// File: rtl/reg_bank_rw_ab_latch.sv
// A/B holding register: captures the packed read data when load is high, otherwise holds.
module ab_latch #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/reg_bank_rw.sv
// 32-entry register bank with two combinational read ports, write-through bypass,
// a sticky write-to-zero error flag and registered A/B copies of the read data.
module reg_bank_rw
    import reg_bank_rw_pkg::*;
#(
    parameter int unsigned        DATA_W   = 32,
    parameter logic [DATA_W-1:0]  SP_RESET = 227,
    parameter logic [DATA_W-1:0]  RA_RESET = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [4:0]        write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [4:0]        read_reg1,
    input  logic [4:0]        read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic              load_ab,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b,
    output logic              wr_zero_err
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wr_zero_err_q;
    logic              wr_zero_err_d;
    logic              wr_en;
    logic              wr_zero;
    logic [2*DATA_W-1:0] ab_q;

    assign wr_en   = reg_write && (write_reg != REG_ZERO);
    assign wr_zero = reg_write && (write_reg == REG_ZERO);

    always_comb begin
        regs_d        = regs_q;
        wr_zero_err_d = wr_zero_err_q;
        if (wr_en) begin
            regs_d[write_reg] = write_data;
        end
        if (wr_zero) begin
            wr_zero_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (5'(i) == REG_SP) begin
                    regs_q[i] <= SP_RESET;
                end else if (5'(i) == REG_RA) begin
                    regs_q[i] <= RA_RESET;
                end else begin
                    regs_q[i] <= '0;
                end
            end
            wr_zero_err_q <= 1'b0;
        end else begin
            regs_q        <= regs_d;
            wr_zero_err_q <= wr_zero_err_d;
        end
    end

    // A write landing on the address being read is forwarded in the same cycle.
    always_comb begin
        if (read_reg1 == REG_ZERO) begin
            read_data1 = '0;
        end else if (wr_en && (write_reg == read_reg1)) begin
            read_data1 = write_data;
        end else begin
            read_data1 = regs_q[read_reg1];
        end
    end

    always_comb begin
        if (read_reg2 == REG_ZERO) begin
            read_data2 = '0;
        end else if (wr_en && (write_reg == read_reg2)) begin
            read_data2 = write_data;
        end else begin
            read_data2 = regs_q[read_reg2];
        end
    end

    ab_latch #(
        .WIDTH (2 * DATA_W)
    ) u_ab_latch (
        .clk   (clk),
        .reset (reset),
        .load  (load_ab),
        .d     ({read_data1, read_data2}),
        .q     (ab_q)
    );

    assign reg_a       = ab_q[2*DATA_W-1:DATA_W];
    assign reg_b       = ab_q[DATA_W-1:0];
    assign wr_zero_err = wr_zero_err_q;

endmodule

// File: tb/tb_reg_bank_rw.sv
// Directed bench for reg_bank_rw: an array-level reference model checked every cycle,
// plus hand-computed literal expectations along the directed sequence.
module tb_reg_bank_rw;

    localparam int unsigned DW = 32;

    logic          clk;
    logic          reset;
    logic          reg_write;
    logic [4:0]    write_reg;
    logic [DW-1:0] write_data;
    logic [4:0]    read_reg1;
    logic [4:0]    read_reg2;
    logic [DW-1:0] read_data1;
    logic [DW-1:0] read_data2;
    logic          load_ab;
    logic [DW-1:0] reg_a;
    logic [DW-1:0] reg_b;
    logic          wr_zero_err;

    int checks   = 0;
    int failures = 0;

    reg_bank_rw #(
        .DATA_W   (DW),
        .SP_RESET (227),
        .RA_RESET (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .reg_write   (reg_write),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .read_reg1   (read_reg1),
        .read_reg2   (read_reg2),
        .read_data1  (read_data1),
        .read_data2  (read_data2),
        .load_ab     (load_ab),
        .reg_a       (reg_a),
        .reg_b       (reg_b),
        .wr_zero_err (wr_zero_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] actual,
                         input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Reference model: a plain array of register contents plus the A/B and flag state.
    logic [DW-1:0] m_regs [32];
    logic [DW-1:0] m_a;
    logic [DW-1:0] m_b;
    logic          m_err;
    logic          m_valid = 1'b0;

    function automatic logic [DW-1:0] m_read(input logic [4:0] addr);
        if (addr == 5'd0) return '0;
        if (reg_write && write_reg != 5'd0 && write_reg == addr) return write_data;
        return m_regs[addr];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= (i == 29) ? 32'd227 : 32'd0;
            m_a     <= '0;
            m_b     <= '0;
            m_err   <= 1'b0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            if (reg_write && write_reg != 5'd0) m_regs[write_reg] <= write_data;
            if (reg_write && write_reg == 5'd0) m_err <= 1'b1;
            if (load_ab) begin
                m_a <= m_read(read_reg1);
                m_b <= m_read(read_reg2);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_rd1", read_data1, m_read(read_reg1));
            check("model_rd2", read_data2, m_read(read_reg2));
            check("model_reg_a", reg_a, m_a);
            check("model_reg_b", reg_b, m_b);
            check("model_err", {31'd0, wr_zero_err}, {31'd0, m_err});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        reg_write  = 1'b0;
        write_reg  = '0;
        write_data = '0;
        read_reg1  = '0;
        read_reg2  = '0;
        load_ab    = 1'b0;
        step();
        reset = 1'b0;

        // Reset contents of every address, both ports.
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i);
            read_reg2 = 5'(31 - i);
            @(negedge clk);
            check("reset_rd1", read_data1, (i == 29) ? 32'd227 : 32'd0);
            check("reset_rd2", read_data2, (31 - i == 29) ? 32'd227 : 32'd0);
            if (i == 0) begin
                check("reset_reg_a", reg_a, 32'd0);
                check("reset_reg_b", reg_b, 32'd0);
                check("reset_err", {31'd0, wr_zero_err}, 32'd0);
            end
            step();
        end

        // Plain write then read next cycle.
        reg_write = 1'b1; write_reg = 5'd8; write_data = 32'hDEADBEEF;
        step();
        reg_write = 1'b0; read_reg1 = 5'd8; read_reg2 = 5'd8;
        @(negedge clk);
        check("wr8_rd1", read_data1, 32'hDEADBEEF);
        check("wr8_rd2", read_data2, 32'hDEADBEEF);
        step();

        // Write to register 0 is dropped and latches the error flag.
        reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h12345678;
        step();
        reg_write = 1'b0; read_reg1 = 5'd0;
        @(negedge clk);
        check("zero_rd", read_data1, 32'd0);
        check("zero_err", {31'd0, wr_zero_err}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            check("zero_err_sticky", {31'd0, wr_zero_err}, 32'd1);
        end
        step();

        // Same-cycle write, bypassed read and A/B capture.
        reg_write = 1'b1; write_reg = 5'd31; write_data = 32'hA5A5A5A5;
        read_reg1 = 5'd31; read_reg2 = 5'd8; load_ab = 1'b1;
        @(negedge clk);
        check("bypass_rd1", read_data1, 32'hA5A5A5A5);
        step();
        reg_write = 1'b0; load_ab = 1'b0;
        @(negedge clk);
        check("capture_reg_a", reg_a, 32'hA5A5A5A5);
        check("capture_reg_b", reg_b, 32'hDEADBEEF);
        check("ra_stored", read_data1, 32'hA5A5A5A5);
        step();

        // Reset wins over a simultaneous write and load.
        reset = 1'b1; reg_write = 1'b1; write_reg = 5'd29; write_data = 32'd5; load_ab = 1'b1;
        step();
        reset = 1'b0; reg_write = 1'b0; load_ab = 1'b0;
        read_reg1 = 5'd29; read_reg2 = 5'd8;
        @(negedge clk);
        check("rst_sp", read_data1, 32'd227);
        check("rst_r8", read_data2, 32'd0);
        check("rst_reg_a", reg_a, 32'd0);
        check("rst_err", {31'd0, wr_zero_err}, 32'd0);
        step();

        // Load known values into A/B, then confirm they hold with load_ab low.
        reg_write = 1'b1; write_reg = 5'd3; write_data = 32'h11111111;
        step();
        reg_write = 1'b0; read_reg1 = 5'd3; read_reg2 = 5'd29; load_ab = 1'b1;
        step();
        load_ab = 1'b0; read_reg1 = 5'd29; read_reg2 = 5'd29;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_rd1", read_data1, 32'd227);
            check("hold_rd2", read_data2, 32'd227);
            check("hold_reg_a", reg_a, 32'h11111111);
            check("hold_reg_b", reg_b, 32'd227);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
